// File: rtl/eth_tx_pkg.sv
// Shared definitions for the Ethernet transmit narrowing reader.
// Holds the frame FSM encoding, the word/beat geometry and a lane-select
// helper used to slice a 64-bit buffer word into 16-bit stream beats.
package eth_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FIN
  } state_t;

  localparam int unsigned WORD_BYTES     = 8;
  localparam int unsigned BEAT_BYTES     = 2;
  localparam int unsigned BEATS_PER_WORD = 4;

  // Beat 0 is the least significant 16 bits (little-endian byte order).
  function automatic logic [15:0] lane_sel(input logic [63:0] word, input logic [1:0] lane);
    return word[{lane, 4'b0000} +: 16];
  endfunction

endpackage

// File: rtl/eth_tx_word_buf.sv
// Two-entry 64-bit word holding buffer (current word + one prefetch).
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   i_push       write i_wdata as the newest entry
//   i_wdata      word to store
//   i_pop        retire the oldest entry
//   o_front      oldest entry; forwards i_wdata while empty
//   o_count      number of held entries (0..2)
module eth_tx_word_buf
  import eth_tx_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_push,
  input  logic [WORD_BYTES*8-1:0]   i_wdata,
  input  logic                      i_pop,
  output logic [WORD_BYTES*8-1:0]   o_front,
  output logic [1:0]                o_count
);

  logic [WORD_BYTES*8-1:0] r_mem [2];
  logic                    r_wp;
  logic                    r_rp;
  logic [1:0]              r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < 2; i++) r_mem[i] <= '0;
      r_wp    <= 1'b0;
      r_rp    <= 1'b0;
      r_count <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wp] <= i_wdata;
        r_wp        <= ~r_wp;
      end
      if (i_pop) r_rp <= ~r_rp;
      // Push and pop together while empty retires the forwarded word in place.
      r_count <= r_count + 2'(i_push) - 2'(i_pop);
    end
  end

  assign o_front = (r_count == 2'd0) ? i_wdata : r_mem[r_rp];
  assign o_count = r_count;

endmodule

// File: rtl/eth_tx_narrow.sv
// Frame-buffer reader for the Ethernet transmit path: reads a frame from
// the 64-bit packet buffer port and emits it as a 16-bit AXI stream.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start_i           start pulse (IDLE only), with base_i / len_i
//   busy_o, done_o    frame in progress / one-cycle completion pulse
//   mem_en_o, mem_addr_o, mem_rdata_i   buffer read port (1-cycle latency)
//   m_tdata_o, m_tkeep_o, m_tvalid_o, m_tlast_o, m_tready_i   stream out
module eth_tx_narrow
  import eth_tx_pkg::*;
#(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned LEN_W  = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_i,
  input  logic [LEN_W-1:0]  len_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              mem_en_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [63:0]       mem_rdata_i,
  output logic [15:0]       m_tdata_o,
  output logic [1:0]        m_tkeep_o,
  output logic              m_tvalid_o,
  output logic              m_tlast_o,
  input  logic              m_tready_i
);

  state_t            r_state, w_state_nxt;
  logic [LEN_W:0]    r_words_left, r_beats_left;
  logic [LEN_W:0]    w_len_words, w_len_beats;
  logic              r_odd, r_rd_pend;
  logic [1:0]        r_lane;
  logic              r_busy, r_done, r_mem_en;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [15:0]       r_tdata;
  logic [1:0]        r_tkeep;
  logic              r_tvalid, r_tlast;
  logic [63:0]       w_front;
  logic [1:0]        w_count;
  logic              w_start, w_adv, w_load, w_last_beat, w_pop, w_issue;
  logic [2:0]        w_occ;

  assign w_len_words = ({1'b0, len_i} + (LEN_W+1)'(WORD_BYTES - 1)) >> $clog2(WORD_BYTES);
  assign w_len_beats = ({1'b0, len_i} + (LEN_W+1)'(BEAT_BYTES - 1)) >> $clog2(BEAT_BYTES);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    case (r_state)
      ST_IDLE: if (start_i) begin
        w_start     = 1'b1;
        w_state_nxt = (len_i == '0) ? ST_FIN : ST_RUN;
      end
      ST_RUN:  if (r_tvalid && r_tlast && m_tready_i) w_state_nxt = ST_FIN;
      ST_FIN:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_adv       = !r_tvalid || m_tready_i;
    w_last_beat = (r_beats_left == (LEN_W+1)'(1));
    // A beat is available from a held word or from the word returning now.
    w_load      = (r_state == ST_RUN) && w_adv && (r_beats_left != '0) &&
                  ((w_count != 2'd0) || r_rd_pend);
    w_pop       = w_load && ((r_lane == 2'(BEATS_PER_WORD - 1)) || w_last_beat);
    // Words held plus both read pipeline stages, after this cycle's retire.
    w_occ       = 3'(w_count) + 3'(r_mem_en) + 3'(r_rd_pend) - 3'(w_pop);
    w_issue     = (r_state == ST_RUN) && (r_words_left != '0) && (w_occ < 3'd2);
  end

  eth_tx_word_buf u_word_buf (
    .clk     (clk),
    .rst     (rst),
    .i_push  (r_rd_pend),
    .i_wdata (mem_rdata_i),
    .i_pop   (w_pop),
    .o_front (w_front),
    .o_count (w_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_mem_en     <= 1'b0;
      r_mem_addr   <= '0;
      r_rd_pend    <= 1'b0;
      r_words_left <= '0;
      r_beats_left <= '0;
      r_odd        <= 1'b0;
      r_lane       <= '0;
      r_tdata      <= '0;
      r_tkeep      <= '0;
      r_tvalid     <= 1'b0;
      r_tlast      <= 1'b0;
    end else begin
      r_busy    <= (w_state_nxt != ST_IDLE);
      r_done    <= (w_state_nxt == ST_FIN);
      r_rd_pend <= r_mem_en;
      r_mem_en  <= 1'b0;
      if (w_start && (len_i != '0)) begin
        r_mem_en     <= 1'b1;
        r_mem_addr   <= base_i;
        r_words_left <= w_len_words - (LEN_W+1)'(1);
        r_beats_left <= w_len_beats;
        r_odd        <= len_i[0];
        r_lane       <= '0;
      end else if (w_issue) begin
        r_mem_en     <= 1'b1;
        r_mem_addr   <= r_mem_addr + ADDR_W'(1);
        r_words_left <= r_words_left - (LEN_W+1)'(1);
      end
      if (w_load) begin
        r_tvalid     <= 1'b1;
        r_tdata      <= lane_sel(w_front, r_lane);
        r_tlast      <= w_last_beat;
        r_tkeep      <= (w_last_beat && r_odd) ? 2'b01 : 2'b11;
        r_beats_left <= r_beats_left - (LEN_W+1)'(1);
        r_lane       <= w_pop ? 2'd0 : r_lane + 2'd1;
      end else if (w_adv) begin
        r_tvalid <= 1'b0;
        r_tlast  <= 1'b0;
      end
    end
  end

  assign busy_o     = r_busy;
  assign done_o     = r_done;
  assign mem_en_o   = r_mem_en;
  assign mem_addr_o = r_mem_addr;
  assign m_tdata_o  = r_tdata;
  assign m_tkeep_o  = r_tkeep;
  assign m_tvalid_o = r_tvalid;
  assign m_tlast_o  = r_tlast;

endmodule

// File: tb/tb_eth_tx_narrow.sv
module tb_eth_tx_narrow;
  localparam int ADDR_W = 9;
  localparam int LEN_W  = 12;

  logic              clk = 1'b0;
  logic              rst;
  logic              start_i;
  logic [ADDR_W-1:0] base_i;
  logic [LEN_W-1:0]  len_i;
  logic              busy_o, done_o, mem_en_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [63:0]       mem_rdata_i;
  logic [15:0]       m_tdata_o;
  logic [1:0]        m_tkeep_o;
  logic              m_tvalid_o, m_tlast_o;
  logic              m_tready_i = 1'b1;

  always #5 clk = ~clk;

  eth_tx_narrow #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .base_i(base_i), .len_i(len_i),
    .busy_o(busy_o), .done_o(done_o), .mem_en_o(mem_en_o), .mem_addr_o(mem_addr_o),
    .mem_rdata_i(mem_rdata_i), .m_tdata_o(m_tdata_o), .m_tkeep_o(m_tkeep_o),
    .m_tvalid_o(m_tvalid_o), .m_tlast_o(m_tlast_o), .m_tready_i(m_tready_i)
  );

  // Packet buffer: byte i of word a holds (8a+i+1) mod 256.
  logic [63:0] mem [512];
  function automatic logic [7:0] pbyte(input int a, input int i);
    return 8'((a * 8 + i + 1) % 256);
  endfunction
  always @(posedge clk) if (mem_en_o) mem_rdata_i <= mem[mem_addr_o];

  typedef struct { logic [15:0] d; logic [1:0] k; logic l; } beat_t;
  beat_t             exp_q[$];
  logic [ADDR_W-1:0] addr_q[$];

  int total = 0, bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  bit rnd_ready = 0;
  initial forever begin
    @(posedge clk); #1;
    m_tready_i = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic fail(input string name);
    total++; bad++;
    $display("FAIL %s: unexpected event (cycle %0d)", name, cyc);
  endtask

  // Per-frame monitor statistics.
  int fv_cyc, hs_cyc, done_cyc, done_cnt, acc_cnt, pres_cnt, iss_cnt, max_out;
  bit prev_stall = 0;
  beat_t prev_b;

  task automatic clear_stats();
    fv_cyc = -1; hs_cyc = -1; done_cyc = -1; done_cnt = 0;
    acc_cnt = 0; pres_cnt = 0; iss_cnt = 0; max_out = 0;
  endtask

  // Monitor: samples on the falling edge; a valid&&ready seen here is the
  // handshake completed by the following rising edge.
  always @(negedge clk) begin
    if (rst) prev_stall = 0;
    else begin
      if (mem_en_o) begin
        iss_cnt++;
        if (addr_q.size() == 0) fail("read_unexpected");
        else chk("read_addr", 64'(mem_addr_o), 64'(addr_q.pop_front()));
      end
      if (m_tvalid_o) begin
        if (prev_stall)
          chk("stable_while_stalled", {m_tdata_o, m_tkeep_o, m_tlast_o}, {prev_b.d, prev_b.k, prev_b.l});
        else begin
          pres_cnt++;
          if (fv_cyc < 0) fv_cyc = cyc;
        end
        if (m_tready_i) begin
          acc_cnt++;
          hs_cyc = cyc;
          if (exp_q.size() == 0) fail("beat_unexpected");
          else begin
            beat_t e;
            logic [15:0] msk;
            e = exp_q.pop_front();
            msk = (e.k == 2'b01) ? 16'h00ff : 16'hffff;
            chk("beat_data", 64'(m_tdata_o & msk), 64'(e.d & msk));
            chk("beat_keep", 64'(m_tkeep_o), 64'(e.k));
            chk("beat_last", 64'(m_tlast_o), 64'(e.l));
          end
        end
      end
      prev_stall = m_tvalid_o && !m_tready_i;
      prev_b = '{m_tdata_o, m_tkeep_o, m_tlast_o};
      if (iss_cnt - pres_cnt / 4 > max_out) max_out = iss_cnt - pres_cnt / 4;
      if (done_o) begin done_cnt++; done_cyc = cyc; end
    end
  end

  task automatic push_beat(input logic [15:0] d, input logic [1:0] k, input logic l);
    exp_q.push_back('{d, k, l});
  endtask

  // Expected beats and read addresses derived from the buffer fill pattern.
  task automatic push_model(input int base, input int len);
    int nb;
    for (int w = 0; w < (len + 7) / 8; w++) addr_q.push_back(ADDR_W'((base + w) % 512));
    nb = (len + 1) / 2;
    for (int b = 0; b < nb; b++) begin
      int j;
      logic [7:0] lo, hi;
      j  = 2 * b;
      lo = pbyte((base + j / 8) % 512, j % 8);
      hi = (j + 1 < len) ? pbyte((base + (j + 1) / 8) % 512, (j + 1) % 8) : 8'h00;
      push_beat({hi, lo}, (j + 1 < len) ? 2'b11 : 2'b01, b == nb - 1);
    end
  endtask

  int t_start;
  task automatic start_frame(input int base, input int len);
    clear_stats();
    @(posedge clk); #1;
    base_i = ADDR_W'(base); len_i = LEN_W'(len); start_i = 1'b1;
    t_start = cyc;
    @(posedge clk); #1;
    start_i = 1'b0;
    chk("busy_after_start", 64'(busy_o), 64'd1);
  endtask

  task automatic wait_done(input int budget, input bit inject);
    int n;
    n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(posedge clk); #1;
      n++;
      if (inject && n == 10) begin
        base_i = 9'd7; len_i = 12'd3; start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
      end
    end
    if (done_cnt == 0) fail("done_timeout");
    repeat (4) @(posedge clk);
    #1;
    chk("beats_pending", 64'(exp_q.size()), 64'd0);
    chk("reads_pending", 64'(addr_q.size()), 64'd0);
    chk("done_pulses", 64'(done_cnt), 64'd1);
    chk("outstanding_le_2", 64'(max_out <= 2), 64'd1);
  endtask

  initial begin
    for (int a = 0; a < 512; a++)
      for (int i = 0; i < 8; i++) mem[a][8*i +: 8] = pbyte(a, i);
    rst = 1'b1; start_i = 1'b0; base_i = '0; len_i = '0;
    clear_stats();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {busy_o, done_o, mem_en_o, m_tvalid_o, m_tlast_o, mem_addr_o, m_tdata_o, m_tkeep_o}, 64'd0);
    rst = 1'b0;

    // len=8 at base 0, hand-computed beats.
    addr_q.push_back(9'd0);
    push_beat(16'h0201, 2'b11, 1'b0); push_beat(16'h0403, 2'b11, 1'b0);
    push_beat(16'h0605, 2'b11, 1'b0); push_beat(16'h0807, 2'b11, 1'b1);
    start_frame(0, 8);
    wait_done(50, 0);
    chk("first_beat_latency", 64'(fv_cyc - t_start), 64'd3);
    chk("beats_contiguous_len8", 64'(hs_cyc - fv_cyc), 64'd3);
    chk("done_after_last", 64'(done_cyc - hs_cyc), 64'd1);

    // len=5: odd length, single word.
    addr_q.push_back(9'd0);
    push_beat(16'h0201, 2'b11, 1'b0); push_beat(16'h0403, 2'b11, 1'b0);
    push_beat(16'h0005, 2'b01, 1'b1);
    start_frame(0, 5);
    wait_done(50, 0);
    chk("reads_len5", 64'(iss_cnt), 64'd1);
    chk("beats_len5", 64'(acc_cnt), 64'd3);

    // base=511, len=24: address wrap, gap-free across words.
    push_model(511, 24);
    start_frame(511, 24);
    wait_done(80, 0);
    chk("beats_len24", 64'(acc_cnt), 64'd12);
    chk("beats_contiguous_len24", 64'(hs_cyc - fv_cyc), 64'd11);

    // len=64 with random tready and an ignored start while busy.
    rnd_ready = 1;
    push_model(100, 64);
    start_frame(100, 64);
    wait_done(1000, 1);
    rnd_ready = 0;
    chk("beats_len64", 64'(acc_cnt), 64'd32);

    // len=0: completes with no read and no beat.
    start_frame(3, 0);
    wait_done(20, 0);
    chk("len0_done_latency", 64'(done_cyc - t_start), 64'd1);
    chk("len0_reads", 64'(iss_cnt), 64'd0);
    chk("len0_beats", 64'(pres_cnt), 64'd0);

    // Reset after the third of 16 beats.
    push_model(40, 32);
    start_frame(40, 32);
    begin
      int n;
      n = 0;
      while (acc_cnt < 3 && n < 100) begin @(posedge clk); n++; end
      if (acc_cnt < 3) fail("reset_test_timeout");
    end
    #1 rst = 1'b1;
    #1;
    chk("abort_outputs", {busy_o, done_o, mem_en_o, m_tvalid_o, m_tlast_o, mem_addr_o, m_tdata_o, m_tkeep_o}, 64'd0);
    exp_q.delete(); addr_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("abort_no_done", 64'(done_cnt), 64'd0);
    chk("abort_no_activity", 64'(pres_cnt), 64'd3);

    // Fresh frame after abort: len=2 gives one full last beat.
    addr_q.push_back(9'd0);
    push_beat(16'h0201, 2'b11, 1'b1);
    start_frame(0, 2);
    wait_done(50, 0);
    chk("beats_len2", 64'(acc_cnt), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

endmodule

// File: doc/eth_tx_narrow.md
# eth_tx_narrow

Frame-buffer reader for the Ethernet transmit path: on a start command it fetches a frame from the 64-bit wide port of the packet buffer and emits it as a 16-bit AXI-stream toward the MAC transmitter. It is the narrowing counterpart of the receive-side 16-to-64 widening buffer. Bytes go out in little-endian order at up to one beat per cycle, with `tkeep`/`tlast` on the final beat.

## Interface
- `ADDR_W`, 9, word-address width of the 64-bit buffer port (512 words, 4 KiB).
- `LEN_W`, 12, frame length field width in bytes (0..4095).
- Clocking: one clock; reset is asynchronous and active-high.
- `clk` in 1: clock.
- `rst` in 1: asynchronous active-high reset.
- `start_i` in 1: start pulse, sampled only in IDLE.
- `base_i` in ADDR_W: first word address of the frame.
- `len_i` in LEN_W: frame length in bytes.
- `busy_o` out 1: frame in progress.
- `done_o` out 1: one-cycle pulse at frame completion.
- `mem_en_o` out 1: buffer read enable.
- `mem_addr_o` out ADDR_W: buffer word address.
- `mem_rdata_i` in 64: read data, valid the cycle after `mem_en_o`.
- `m_tdata_o` out 16: stream data.
- `m_tkeep_o` out 2: byte valid, bit0 = `tdata[7:0]`.
- `m_tvalid_o` out 1: stream valid.
- `m_tlast_o` out 1: last beat of frame.
- `m_tready_i` in 1: stream ready.

## Operation
- States: IDLE, RUN, FIN.
  - IDLE: `start_i` latches `base_i` and `len_i`, then goes to RUN. If `len_i`=0 it goes to FIN instead, with no read and no beat.
  - RUN: fetch words and stream beats.
  - FIN: assert `done_o` for one cycle, then return to IDLE.
- `start_i` is ignored outside IDLE.
- Word count is ceil(len/8). Beat count is ceil(len/2).
- Word read order: `base`, `base+1`, … The address wraps modulo 2^ADDR_W (511→0).
- Each 64-bit word is emitted as four beats, LSB first: `[15:0]`, `[31:16]`, `[47:32]`, `[63:48]`.
- Only beats up to the frame length are emitted. Leftover lanes of the final word are discarded.
- Final beat:
  - `m_tlast_o`=1.
  - `m_tkeep_o`=2'b01 if len is odd, else 2'b11.
  - `tdata[15:8]` is don't-care when `tkeep`=01.
- All other beats: `tkeep`=11, `tlast`=0.
- Buffering: a current-word register plus one prefetch register.
  - A read is issued when a register slot will be free at data return and words remain.
  - There are never more than two words outstanding or held.
- AXI rules:
  - Once `m_tvalid_o` is high, it and `tdata`/`tkeep`/`tlast` stay stable until `m_tready_i`.
  - `m_tvalid_o` does not depend combinationally on `m_tready_i`.
- `busy_o` is high from the cycle after an accepted start through the FIN cycle inclusive.
- Reset mid-frame aborts immediately: no `done_o` and no further beats. The next start begins a fresh frame.

## Timing
- Reset values: `busy_o`, `done_o`, `mem_en_o`, `m_tvalid_o`, `m_tlast_o` = 0; `mem_addr_o`, `m_tdata_o`, `m_tkeep_o` = 0; state = IDLE.
- Start accepted at edge T:
  - `mem_en_o`=1 with `mem_addr_o`=base during cycle T+1.
  - Data is captured at T+2.
  - `m_tvalid_o`=1 from cycle T+3. First-beat latency is 3 cycles.
- With `m_tready_i` held high, beats are continuous with no bubbles for the whole frame, including across word boundaries.
- The cycle after the last-beat handshake is FIN (`done_o`=1). IDLE follows, and a new start is accepted in that IDLE cycle.
- `len_i`=0: FIN the cycle after the start, so `done_o` pulses at T+1.
- Outputs are registered. There is no combinational path from any input to any output.

## Structure
- Package `eth_tx_pkg` holds:
  - the state enum (IDLE/RUN/FIN);
  - `WORD_BYTES`=8, `BEAT_BYTES`=2, `BEATS_PER_WORD`=4.
- Sub-module `eth_tx_word_buf`: 2-entry 64-bit word holding buffer with push/pop/count. The top level holds the FSM, the address and length counters, the lane mux and the output register.

## Test plan
- base=0, len=8, word0=0x0807060504030201, tready=1 → beats 0x0201, 0x0403, 0x0605, 0x0807 on consecutive cycles from T+3; `tkeep`=11 on all; `tlast` on the 4th beat; `done_o` the next cycle.
- len=5 → 3 beats: 0x0201, 0x0403, then 0x??05 with `tkeep`=01 and `tlast`=1. Exactly one memory read is issued.
- base=511, len=24, tready=1 → reads issued at 511, 0, 1. The 12 beats are gap-free and `tlast` is on beat 12.
- len=64 with random `tready` (50%) → output matches the reference byte stream. Data is stable whenever valid&&!ready, and there are never more than 2 words outstanding.
- len=0 → `done_o` at T+1, no `mem_en_o`, no `tvalid`. A `start_i` pulse while busy has no effect on the current frame.
- `rst` asserted mid-frame (after beat 3 of 16) → all outputs 0 immediately, no `done_o`. A new start with len=2 then yields a single beat with `tkeep`=11 and `tlast`=1.
